// File: rtl/dma_ctrl16.sv
// dma_ctrl16: memory-mapped block-copy DMA controller with CPU hold/busy bus handshake
module dma_ctrl16 #(
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  reg_sel,
  input  logic [1:0]            reg_addr,
  input  logic                  reg_we,
  input  logic [ADDR_WIDTH-1:0] reg_wdata,
  output logic [ADDR_WIDTH-1:0] reg_rdata,
  output logic                  cpu_hold,
  input  logic                  cpu_busy,
  output logic                  bus_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [ADDR_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_rdata,
  output logic                  done_irq
);
  typedef enum logic [2:0] {IDLE, REQ, RD, WAIT, WR, REL} state_t;
  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] src, dst, cnt, rd_val;
  logic ie, done, aborted, active, abort_pend;
  logic [1:0] wcnt;
  logic reg_wr, ctrl_wr, start_wr, abort_now, go;
  assign reg_wr    = reg_sel & reg_we;
  assign ctrl_wr   = reg_wr & (reg_addr == 2'd3);
  assign start_wr  = ctrl_wr & reg_wdata[0] & ~active;
  assign abort_now = abort_pend | (ctrl_wr & reg_wdata[1] & active);
  assign go        = start_wr & (cnt != '0);
  assign rd_val    = reg_addr == 2'd0 ? src :
                     reg_addr == 2'd1 ? dst :
                     reg_addr == 2'd2 ? cnt :
                     ADDR_WIDTH'({aborted, done, 5'd0, ie, 1'b0, active});
  assign cpu_hold  = state inside {REQ, RD, WAIT, WR};
  assign bus_grant = state inside {RD, WAIT, WR};
  assign mem_we    = state == WR;
  assign mem_addr  = state == WR ? dst : bus_grant ? src : '0;
  assign done_irq  = done & ie;
  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  // next-state: an abort seen in REQ skips the copy, otherwise it takes effect after the word in flight
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? REQ : IDLE;
      REQ:     state_nx = abort_now ? REL : cpu_busy ? REQ : RD;
      RD:      state_nx = WAIT;
      WAIT:    state_nx = wcnt == WAIT_LAST ? WR : WAIT;
      WR:      state_nx = (cnt == ADDR_WIDTH'(1) || abort_now) ? REL : RD;
      REL:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // registers, transfer counters and read-data capture; REL's done-set is last so it beats a done-clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src        <= '0;
      dst        <= '0;
      cnt        <= '0;
      ie         <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      active     <= 1'b0;
      abort_pend <= 1'b0;
      wcnt       <= '0;
      mem_wdata  <= '0;
      reg_rdata  <= '0;
    end else begin
      if (reg_wr && !active && reg_addr == 2'd0) src <= reg_wdata;
      if (reg_wr && !active && reg_addr == 2'd1) dst <= reg_wdata;
      if (reg_wr && !active && reg_addr == 2'd2) cnt <= reg_wdata;
      if (ctrl_wr) ie <= reg_wdata[2];
      if (ctrl_wr && reg_wdata[8]) done <= 1'b0;
      if (start_wr && !go) begin
        done    <= 1'b1;
        aborted <= 1'b0;
      end
      if (go) begin
        active     <= 1'b1;
        done       <= 1'b0;
        aborted    <= 1'b0;
        abort_pend <= 1'b0;
      end
      if (ctrl_wr && reg_wdata[1] && active) abort_pend <= 1'b1;
      if (state == RD) wcnt <= '0;
      if (state == WAIT) wcnt <= wcnt + 2'd1;
      if (state == WAIT && wcnt == WAIT_LAST) mem_wdata <= mem_rdata;
      if (state == WR) begin
        src <= src + 1'b1;
        dst <= dst + 1'b1;
        cnt <= cnt - 1'b1;
      end
      if (state == REL) begin
        done       <= 1'b1;
        aborted    <= abort_now;
        active     <= 1'b0;
        abort_pend <= 1'b0;
      end
      if (reg_sel) reg_rdata <= rd_val;
    end
  end
endmodule

// File: tb/tb_dma_ctrl16.sv
// tb_dma_ctrl16: scoreboard bench for dma_ctrl16 against an array-copy reference model
module tb_dma_ctrl16;
  logic clk = 0, reset_n = 0, reg_sel = 0, reg_we = 0, cpu_busy = 0;
  logic [1:0] reg_addr = 0;
  logic [15:0] reg_wdata = 0, reg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_hold, bus_grant, mem_we, done_irq;
  logic [15:0] ram [0:65535];
  logic [15:0] mm [0:65535];
  logic fill = 0, bd_we = 0;
  logic [15:0] bd_addr = 0, bd_data = 0;
  int unsigned seed;
  int errors = 0, checks = 0, hold_cnt = 0;
  logic [31:0] wq[$];
  logic [15:0] rq[$];
  logic in_rd = 0;

  dma_ctrl16 dut (
    .clk(clk), .reset_n(reset_n), .reg_sel(reg_sel), .reg_addr(reg_addr), .reg_we(reg_we),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .cpu_hold(cpu_hold), .cpu_busy(cpu_busy),
    .bus_grant(bus_grant), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(int i);
    return 16'((i * 40503) ^ (i >> 5)) ^ seed[15:0];
  endfunction

  // synchronous single-port memory with 1-cycle read latency
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 65536; i++) ram[i] <= pat(i);
    end else begin
      if (bd_we) ram[bd_addr] <= bd_data;
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: bus invariants plus read/write scoreboards
  always @(negedge clk) begin
    chk("grant_implies_hold", 32'(bus_grant & ~cpu_hold), 0);
    chk("we_implies_grant", 32'(mem_we & ~bus_grant), 0);
    if (bus_grant && !mem_we && !in_rd) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got addr %h expected no read", mem_addr);
      end else chk("read_addr", 32'(mem_addr), 32'(rq.pop_front()));
    end
    in_rd = bus_grant && !mem_we;
    if (mem_we) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        logic [31:0] e;
        e = wq.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e[31:16]));
        chk("write_data", 32'(mem_wdata), 32'(e[15:0]));
      end
    end
    if (cpu_hold) hold_cnt++;
  end

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] v);
    @(negedge clk); reg_sel = 1; reg_we = 1; reg_addr = a; reg_wdata = v;
    @(negedge clk); reg_sel = 0; reg_we = 0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [15:0] v);
    @(negedge clk); reg_sel = 1; reg_we = 0; reg_addr = a;
    @(negedge clk); reg_sel = 0; v = reg_rdata;
  endtask

  task automatic chk_regs(input string nm, input logic [15:0] s, d, c, st);
    logic [15:0] v;
    rd_reg(0, v); chk({nm, "_src"}, 32'(v), 32'(s));
    rd_reg(1, v); chk({nm, "_dst"}, 32'(v), 32'(d));
    rd_reg(2, v); chk({nm, "_cnt"}, 32'(v), 32'(c));
    rd_reg(3, v); chk({nm, "_status"}, 32'(v), 32'(st));
  endtask

  task automatic poke(input logic [15:0] a, v);
    @(negedge clk); bd_we = 1; bd_addr = a; bd_data = v; mm[a] = v;
    @(negedge clk); bd_we = 0;
  endtask

  // reference: ascending word copy over a flat 64K array, addresses wrap at 16 bits
  task automatic model_copy(input logic [15:0] s, d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] w;
      rq.push_back(s);
      w = mm[s];
      mm[d] = w;
      wq.push_back({d, w});
      s++;
      d++;
    end
  endtask

  task automatic run_copy(input logic [15:0] s, d, input int n, input int b, output int t, output int g);
    wr_reg(0, s); wr_reg(1, d); wr_reg(2, 16'(n));
    model_copy(s, d, n);
    cpu_busy = (b > 0);
    wr_reg(3, 16'h0005);
    t = 0; g = -1;
    while (!done_irq && t < 400) begin
      @(negedge clk); t++;
      if (t == b) cpu_busy = 0;
      if (bus_grant && g < 0) g = t;
    end
  endtask

  initial begin
    int t, g, wes, h0, n, b;
    logic [15:0] v, s, d;
    seed = $urandom;
    for (int i = 0; i < 65536; i++) mm[i] = pat(i);
    fill = 1;
    @(negedge clk); fill = 0;
    @(negedge clk);
    chk("rst_outs", 32'({cpu_hold, bus_grant, mem_we, done_irq}), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_reg_rdata", 32'(reg_rdata), 0);
    reset_n = 1;
    chk_regs("rst", 0, 0, 0, 0);
    // basic copy
    poke(16'h0010, 16'h00A1); poke(16'h0011, 16'h00B2); poke(16'h0012, 16'h00C3); poke(16'h0013, 16'h00D4);
    run_copy(16'h0010, 16'h0100, 4, 0, t, g);
    chk("basic_cycles", 32'(t), 14);
    chk("basic_irq", 32'(done_irq), 1);
    chk("basic_hold", 32'(cpu_hold), 0);
    chk("basic_ram0", 32'(ram[16'h0100]), 32'h00A1);
    chk("basic_ram3", 32'(ram[16'h0103]), 32'h00D4);
    chk_regs("basic", 16'h0014, 16'h0104, 0, 16'h0104);
    // busy handshake
    run_copy(16'h2000, 16'h3000, 6, 5, t, g);
    chk("busy_cycles", 32'(t), 25);
    chk("busy_first_grant", 32'(g), 6);
    chk_regs("busy", 16'h2006, 16'h3006, 0, 16'h0104);
    // zero count
    wr_reg(2, 0);
    h0 = hold_cnt;
    wr_reg(3, 16'h0005);
    repeat (3) @(negedge clk);
    chk("zero_no_hold", 32'(hold_cnt), 32'(h0));
    chk("zero_irq", 32'(done_irq), 1);
    chk_regs("zero", 16'h2006, 16'h3006, 0, 16'h0104);
    // start and SRC write while active are ignored
    wr_reg(0, 16'h4000); wr_reg(1, 16'h4100); wr_reg(2, 8);
    model_copy(16'h4000, 16'h4100, 8);
    wr_reg(3, 16'h0005);
    wr_reg(0, 16'hDEAD);
    wr_reg(3, 16'h0005);
    t = 0;
    while (!done_irq && t < 400) begin @(negedge clk); t++; end
    chk("active_done", 32'(t < 400), 1);
    chk_regs("active", 16'h4008, 16'h4108, 0, 16'h0104);
    // abort during the 3rd write cycle
    wr_reg(0, 16'h5000); wr_reg(1, 16'h5004); wr_reg(2, 10);
    model_copy(16'h5000, 16'h5004, 3);
    wr_reg(3, 16'h0005);
    wes = 0; t = 0;
    while (t < 200) begin
      @(negedge clk); t++;
      if (mem_we) wes++;
      if (wes == 3) break;
    end
    chk("abort_reached_wr3", 32'(wes), 3);
    reg_sel = 1; reg_we = 1; reg_addr = 3; reg_wdata = 16'h0002;
    @(negedge clk); reg_sel = 0; reg_we = 0;
    repeat (3) @(negedge clk);
    chk_regs("abort", 16'h5003, 16'h5007, 7, 16'h0300);
    // address wrap
    run_copy(16'hFFFE, 16'h0000, 3, 0, t, g);
    chk("wrap_cycles", 32'(t), 11);
    chk_regs("wrap", 16'h0001, 16'h0003, 0, 16'h0104);
    // randomized copies
    for (int k = 0; k < 6; k++) begin
      s = 16'($urandom); d = 16'($urandom);
      n = $urandom_range(1, 12); b = $urandom_range(0, 3);
      run_copy(s, d, n, b, t, g);
      chk("rand_cycles", 32'(t), 32'(3 * n + 2 + b));
      chk("rand_first_grant", 32'(g), 32'(b + 1));
      chk_regs("rand", s + 16'(n), d + 16'(n), 0, 16'h0104);
    end
    // reset during WAIT of the second word
    wr_reg(0, 16'h6000); wr_reg(1, 16'h7000); wr_reg(2, 5);
    model_copy(16'h6000, 16'h7000, 1);
    rq.push_back(16'h6001);
    wr_reg(3, 16'h0005);
    t = 0;
    while (!mem_we && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_in_wait", 32'({bus_grant, mem_we}), 32'h2);
    reset_n = 0;
    @(negedge clk);
    chk("rst_mid_outs", 32'({cpu_hold, bus_grant, mem_we, done_irq}), 0);
    chk("rst_mid_wdata", 32'(mem_wdata), 0);
    chk("rst_mid_addr", 32'(mem_addr), 0);
    reset_n = 1;
    chk_regs("rst_mid", 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    chk("writes_drained", 32'(wq.size()), 0);
    chk("reads_drained", 32'(rq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
